// File: rtl/modem_pkg.sv
// Shared modem datapath types and the default sizing used by the filter blocks.
package modem_pkg;

  localparam int SAMPLE_WIDTH   = 18;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_DECIM      = 1;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tap_shift_buffer_if.sv
// Sample stream in, parallel tap window out, for tap_shift_buffer.
interface tap_shift_buffer_if
  import modem_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH
) ();

  localparam int FILL_W = $clog2(DEPTH + 1);

  logic                                           clr;
  logic                                           in_valid;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]              in_data;
  logic [NUM_CH-1:0][DEPTH-1:0][DATA_WIDTH-1:0]   taps_out;
  logic [FILL_W-1:0]                              fill_count;
  logic                                           taps_full;
  logic                                           out_strobe;

  modport master (
    output clr, in_valid, in_data,
    input  taps_out, fill_count, taps_full, out_strobe
  );

  modport slave (
    input  clr, in_valid, in_data,
    output taps_out, fill_count, taps_full, out_strobe
  );

endinterface

// File: rtl/tap_shift_buffer_tap_chain.sv
// Single-channel DEPTH-deep shift register; taps[0] is the newest sample.
module tap_chain
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 18
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              shift_en,
  input  logic [DATA_WIDTH-1:0]             d,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]  taps
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the taps are reset because the window is observable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (clr) begin
      taps <= '0;
    end else if (shift_en) begin
      taps <= {taps[DEPTH-2:0], d};
    end
  end

endmodule

// File: rtl/tap_shift_buffer.sv
// Multi-channel tapped delay line with fill tracking and a decimated window strobe.
module tap_shift_buffer
  import modem_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DECIM      = DEF_DECIM
) (
  input  logic               clk,
  input  logic               rst_n,
  tap_shift_buffer_if.slave  bus
);

  localparam int FILL_W  = $clog2(DEPTH + 1);
  localparam int PHASE_W = cnt_width(DECIM);

  localparam logic [FILL_W-1:0]  FILL_MAX   = FILL_W'(DEPTH);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

  logic                accept;
  logic [FILL_W-1:0]   fill_count;
  logic [FILL_W-1:0]   fill_next;
  logic [PHASE_W-1:0]  phase;
  logic                taps_full;
  logic                out_strobe;

  // clr wins over in_valid, so a sample presented alongside clr is dropped.
  assign accept = bus.in_valid & ~bus.clr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tap_chain #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_chain (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.clr),
      .shift_en (accept),
      .d        (bus.in_data[c]),
      .taps     (bus.taps_out[c])
    );
  end

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    fill_next = fill_count;
    if (accept && (fill_count != FILL_MAX)) begin
      fill_next = fill_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
      phase      <= '0;
      taps_full  <= 1'b0;
      out_strobe <= 1'b0;
    end else if (bus.clr) begin
      fill_count <= '0;
      phase      <= '0;
      taps_full  <= 1'b0;
      out_strobe <= 1'b0;
    end else begin
      fill_count <= fill_next;
      taps_full  <= (fill_next == FILL_MAX);
      // Strobe lands on the same edge that loads the window it announces.
      out_strobe <= accept && (phase == PHASE_LAST) && (fill_next == FILL_MAX);
      if (accept) begin
        phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
      end
    end
  end

  assign bus.fill_count = fill_count;
  assign bus.taps_full  = taps_full;
  assign bus.out_strobe = out_strobe;

endmodule
